// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side controller for the 32-bit ALU datapath.
// Accepts an R-type request, decodes funct into the ALU op and holds the
// operands stable for SETTLE_CYCLES cycles. It then captures result and flags
// and returns them over a valid/ready response channel.
// Optional feature macro: ALU_ISSUE_CTRL_STATS_EN adds saturating counters
// stat_ops (legal responses handshaken) and stat_ovf (those with overflow).
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow
`ifdef ALU_ISSUE_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_ovf
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] settle_cnt;
  logic [2:0] dec_op;
  logic       dec_legal;
  logic       accept;
  logic       resp_fire;

  // Decode the MIPS funct code into {binv, op[1:0]} and flag unknown codes
  always_comb begin
    dec_op    = 3'b000;
    dec_legal = 1'b0;
    case (req_funct)
      6'h20: begin dec_op = 3'b010; dec_legal = 1'b1; end
      6'h22: begin dec_op = 3'b110; dec_legal = 1'b1; end
      6'h24: begin dec_op = 3'b000; dec_legal = 1'b1; end
      6'h25: begin dec_op = 3'b001; dec_legal = 1'b1; end
      6'h2A: begin dec_op = 3'b111; dec_legal = 1'b1; end
      default: begin dec_op = 3'b000; dec_legal = 1'b0; end
    endcase
  end

  // Next-state and handshake outputs; only one request is ever in flight
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = dec_legal ? SETTLE : RESP;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = req_valid & req_ready;
  assign resp_fire = resp_valid & resp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand launch, settle countdown and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 3'b000;
      settle_cnt    <= 4'd0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              alu_a      <= req_a;
              alu_b      <= req_b;
              alu_op     <= dec_op;
              settle_cnt <= CNT_INIT;
            end else begin
              resp_result   <= '0;
              resp_zero     <= 1'b0;
              resp_overflow <= 1'b0;
              resp_err      <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            resp_result   <= alu_result;
            resp_zero     <= alu_zero;
            resp_overflow <= alu_overflow;
            resp_err      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_CTRL_STATS_EN
  // Saturating counts of legal responses and overflowing ones, bumped on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops <= 16'h0000;
      stat_ovf <= 16'h0000;
    end else if (resp_fire && !resp_err) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'h0001;
      if (resp_overflow && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural
// ALU model attached to the alu_* ports.
module tb_alu_issue_ctrl;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_overflow;
  logic        resp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
`ifdef ALU_ISSUE_CTRL_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_ovf;
`endif

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct     (req_funct),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow),
    .resp_err      (resp_err),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow)
`ifdef ALU_ISSUE_CTRL_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_ovf      (stat_ovf)
`endif
  );

  // Behavioural ripple ALU: binv inverts B and feeds carry-in, LESS uses sign^overflow
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  logic        alu_less;
  always_comb begin
    alu_bb       = alu_op[2] ? ~alu_b : alu_b;
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {32'd0, alu_op[2]};
    alu_overflow = (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31]);
    alu_less     = alu_sum[31] ^ alu_overflow;
    alu_result   = 32'd0;
    case (alu_op[1:0])
      2'b00: alu_result = alu_a & alu_bb;
      2'b01: alu_result = alu_a | alu_bb;
      2'b10: alu_result = alu_sum[31:0];
      default: alu_result = {31'd0, alu_less};
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops the oldest expectation and compares
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_resp: got result 0x%08h with no pending request", resp_result);
      end else begin
        e = sbq.pop_front();
        checkOutput("resp_result", resp_result, e.result);
        checkOutput("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
        checkOutput("resp_overflow", {31'd0, resp_overflow}, {31'd0, e.ovf});
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] exp_op, input logic legal,
                               input logic [31:0] exp_res, input logic exp_zero,
                               input logic exp_ovf, input int hold_cycles);
    exp_t e;
    waitReady();
    req_funct  = funct;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    e.result = exp_res;
    e.zero   = exp_zero;
    e.ovf    = exp_ovf;
    e.err    = ~legal;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_funct = 6'h3F;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h1234_5678;
    checkOutput("alu_op", {29'd0, alu_op}, {29'd0, exp_op});
    if (legal) begin
      checkOutput("alu_a", alu_a, a);
      checkOutput("alu_b", alu_b, b);
      checkOutput("resp_valid_early", {31'd0, resp_valid}, 32'd0);
      for (int i = 0; i < SETTLE - 1; i++) begin
        @(posedge clk); #1;
        checkOutput("resp_valid_settle", {31'd0, resp_valid}, 32'd0);
      end
      @(posedge clk); #1;
    end
    checkOutput("resp_valid_up", {31'd0, resp_valid}, 32'd1);
    checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < hold_cycles; i++) begin
      req_valid = 1'b1;
      req_funct = 6'h20;
      @(posedge clk); #1;
      checkOutput("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("hold_result", resp_result, exp_res);
      checkOutput("hold_err", {31'd0, resp_err}, {31'd0, ~legal});
      checkOutput("hold_ovf", {31'd0, resp_overflow}, {31'd0, exp_ovf});
      if (legal) checkOutput("hold_alu_a", alu_a, a);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    checkOutput("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct  = 6'h00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_resp_result", resp_result, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // funct, a, b, alu_op, legal, result, zero, ovf, hold
    applyStimulus(6'h20, 32'd5, 32'd7, 3'b010, 1'b1, 32'd12, 1'b0, 1'b0, 0);
    applyStimulus(6'h22, 32'd9, 32'd9, 3'b110, 1'b1, 32'd0, 1'b1, 1'b0, 0);
    applyStimulus(6'h2A, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1, 32'd1, 1'b0, 1'b0, 0);
    applyStimulus(6'h24, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 0);
    applyStimulus(6'h25, 32'h0000_F0F0, 32'h0000_0FF0, 3'b001, 1'b1, 32'h0000_FFF0, 1'b0, 1'b0, 0);
    applyStimulus(6'h00, 32'd3, 32'd4, 3'b001, 1'b0, 32'd0, 1'b0, 1'b0, 2);
    applyStimulus(6'h20, 32'h7FFF_FFFF, 32'd1, 3'b010, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 5);

    // Reset in the middle of SETTLE: everything returns to reset values, no response
    waitReady();
    req_funct = 6'h20;
    req_a     = 32'd100;
    req_b     = 32'd200;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrst_alu_a", alu_a, 32'd0);
    checkOutput("midrst_alu_b", alu_b, 32'd0);
    checkOutput("midrst_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("midrst_resp_result", resp_result, 32'd0);
    checkOutput("midrst_resp_ovf", {31'd0, resp_overflow}, 32'd0);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    resp_ready = 1'b0;

    applyStimulus(6'h20, 32'd1, 32'd2, 3'b010, 1'b1, 32'd3, 1'b0, 1'b0, 0);
    applyStimulus(6'h20, 32'h7FFF_FFFF, 32'd1, 3'b010, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 0);
    applyStimulus(6'h20, 32'd10, 32'd20, 3'b010, 1'b1, 32'd30, 1'b0, 1'b0, 0);
`ifdef ALU_ISSUE_CTRL_STATS_EN
    checkOutput("stat_ops", {16'd0, stat_ops}, 32'd3);
    checkOutput("stat_ovf", {16'd0, stat_ovf}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester-side controller for the 32-bit ALU datapath.
- Accepts R-type requests (funct plus two operands) over a valid/ready handshake and decodes funct into the 3-bit ALU op {binv, op[1:0]}.
- Drives registered, stable operands into the ALU for a programmable number of settle cycles to cover the ripple/carry path, then captures result and flags.
- Returns the captured values over a valid/ready response channel. Sits between the multicycle control/regfile and the ALU.

Parameters:
- SETTLE_CYCLES, 2, number of cycles alu_* inputs are held before capture; legal range 1..15.
- WIDTH, 32, datapath width; fixed at 32 for this release.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_funct  in  6  MIPS funct code.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_result  out  32  captured ALU result.
- resp_zero  out  1  captured ALU zero flag.
- resp_overflow  out  1  captured ALU overflow output.
- resp_err  out  1  illegal funct.
- alu_a  out  32  ALU operand A (registered).
- alu_b  out  32  ALU operand B (registered).
- alu_op  out  3  ALU op: [2]=binv, [1:0]: 00 AND, 01 OR, 10 ADD, 11 LESS.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow output.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs take these values:
  - state=IDLE, req_ready=1, resp_valid=0.
  - resp_result=0, resp_zero=0, resp_overflow=0, resp_err=0.
  - alu_a=0, alu_b=0, alu_op=3'b000, settle counter=0.
  - Reset overrides any in-flight operation.
- Decode:
  - 0x20 add → 010
  - 0x22 sub → 110
  - 0x24 and → 000
  - 0x25 or → 001
  - 0x2A slt → 111
  - Any other funct is illegal.
- IDLE: req_ready=1. On req_valid & req_ready at cycle T:
  - Legal funct: alu_a/alu_b/alu_op load at the T edge; counter=SETTLE_CYCLES-1; go to SETTLE.
  - Illegal funct: alu_* unchanged; resp_result=0, resp_zero=0, resp_overflow=0, resp_err=1; go to RESP (resp_valid visible at T+1).
- SETTLE: req_ready=0 and alu_* held constant.
  - If counter≠0, decrement.
  - If counter=0, capture alu_result/alu_zero/alu_overflow into resp_*, set resp_err=0, go to RESP.
  - resp_valid is first visible at cycle T+1+SETTLE_CYCLES.
- RESP: resp_valid=1 and req_ready=0. All resp_* stay stable until resp_valid & resp_ready. Then resp_valid=0 next cycle and state=IDLE.
- One request in flight at a time. The next request can be accepted no earlier than the cycle after the response handshake.
- alu_* keep their last driven values in IDLE/RESP; they are not cleared.
- req_* are sampled only on the accept edge. Later changes are ignored.
- Captured flags come straight from the ALU; the block does no sign or overflow reinterpretation.

Optional Feature:
- Macro ALU_ISSUE_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_ops[15:0] (count of legal responses handshaken) and stat_ovf[15:0] (count of those with resp_overflow=1).
  - Both are saturating at 16'hFFFF and cleared by rst_n.
  - Both increment on the response handshake edge.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=2, ALU model; add a=5, b=7 accepted at T → alu_op=010 at T+1; resp_valid at T+3 with result=12, zero=0, err=0.
- sub a=9, b=9 → alu_op=110; resp_result=0, resp_zero=1; resp_ready=1 gives resp_valid=0 and req_ready=1 next cycle.
- slt a=32'hFFFFFFFF, b=1 (model returns 1) → alu_op=111, result=1; and/or 0xF0F0/0x0FF0 → alu_op 000/001, results 0x00F0/0xFFF0.
- funct=0x00 at T → resp_valid at T+1, err=1, result=0; alu_op unchanged from the previous op.
- Hold resp_ready=0 for 5 cycles in RESP → resp_* bit-stable, req_ready=0, a new req_valid is not accepted; release → handshake, then IDLE.
- rst_n=0 during SETTLE → next edge all outputs at reset values, no response issued; with ALU_ISSUE_CTRL_STATS_EN, 3 adds (one overflowing) → stat_ops=3, stat_ovf=1.
